bk_sd_sequencer: RTL



---
 rtl/bk_pkg.sv | 14 +
 rtl/bk_autosave_timer.sv | 35 +++
 rtl/bk_sd_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM SD sequencer.
package bk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    FMT
  } bk_state_t;

  // Default save-image header written by a format request, word 0 first.
  localparam logic [15:0] BK_FMT_HDR [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

endpackage

// File: rtl/bk_autosave_timer.sv
// Quiet-period counter for the optional auto-save; pulses trig once the backup RAM
// has gone AUTOSAVE_CYC cycles without a write while the sequencer is idle.
module bk_autosave_timer #(
  parameter logic [23:0] AUTOSAVE_CYC = 24'd10_000_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic bram_wr,
  input  logic hold,
  output logic trig
);

  logic [23:0] cnt_q, cnt_d;

  // Saturates at the threshold so the trigger persists until a write or a sequence clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (hold || bram_wr) begin
      cnt_d = 24'd0;
    end else if (cnt_q != AUTOSAVE_CYC) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign trig = (cnt_q == AUTOSAVE_CYC) && !hold;

endmodule

// File: rtl/bk_sd_sequencer.sv
// Backup-RAM <-> SD sector sequencer: save/load of one slot, format header, reset-during-load.
// Define BK_AUTOSAVE_EN to build in the quiet-period auto-save.
module bk_sd_sequencer
  import bk_pkg::*;
#(
  parameter int          SECTORS      = 16,
  parameter int          SLOT_W       = 2,
  parameter logic [23:0] AUTOSAVE_CYC = 24'd10_000_000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              download,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic              img_size_nz,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              format_req,
  input  logic [SLOT_W-1:0] slot,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic              bram_wr,
  output logic              fmt_we,
  output logic [1:0]        fmt_addr,
  output logic [15:0]       fmt_data,
  output logic              bk_ena,
  output logic              busy,
  output logic              loading,
  output logic              dirty
);

  localparam int IDX_W = $clog2(SECTORS);

  bk_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              isLoad_q, isLoad_d;
  logic [1:0]        fmtCnt_q, fmtCnt_d;
  logic              dirty_q, dirty_d;
  logic              bkEna_q, bkEna_d;
  logic              loadReq_q, saveReq_q, fmtReq_q, download_q, ack_q;

  logic loadEdge, saveEdge, fmtEdge, ackRise, ackFall;
  logic saveStart, loadDone, autoTrig;

  assign loadEdge = load_req & ~loadReq_q;
  assign saveEdge = save_req & ~saveReq_q;
  assign fmtEdge  = format_req & ~fmtReq_q;
  assign ackRise  = sd_ack & ~ack_q;
  assign ackFall  = ~sd_ack & ack_q;

`ifdef BK_AUTOSAVE_EN
  bk_autosave_timer #(
    .AUTOSAVE_CYC(AUTOSAVE_CYC)
  ) u_timer (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bram_wr(bram_wr),
    .hold   (busy),
    .trig   (autoTrig)
  );
`else
  logic [23:0] unused_cfg;
  assign unused_cfg = AUTOSAVE_CYC;
  assign autoTrig   = 1'b0;
`endif

  // Sequence control; slot is latched at request so later slot changes cannot move the LBA.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    isLoad_d  = isLoad_q;
    fmtCnt_d  = fmtCnt_q;
    saveStart = 1'b0;
    loadDone  = 1'b0;
    case (state_q)
      IDLE: begin
        if (loadEdge && bkEna_q) begin
          state_d  = REQ;
          isLoad_d = 1'b1;
          idx_d    = '0;
          slot_d   = slot;
        end else if ((saveEdge || (autoTrig && dirty_q && !loadEdge && !fmtEdge)) && bkEna_q) begin
          state_d   = REQ;
          isLoad_d  = 1'b0;
          idx_d     = '0;
          slot_d    = slot;
          saveStart = 1'b1;
        end else if (fmtEdge) begin
          state_d  = FMT;
          fmtCnt_d = 2'd0;
        end
      end
      REQ: begin
        if (ackRise) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (ackFall) begin
          if (idx_q == IDX_W'(SECTORS - 1)) begin
            state_d  = IDLE;
            loadDone = isLoad_q;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = REQ;
          end
        end
      end
      FMT: begin
        fmtCnt_d = fmtCnt_q + 2'd1;
        if (fmtCnt_q == 2'd3) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set beats clear for both the image-valid flag and the dirty flag.
  always_comb begin
    bkEna_d = bkEna_q;
    if (download && img_mounted && img_size_nz && !img_readonly) begin
      bkEna_d = 1'b1;
    end else if (download && !download_q) begin
      bkEna_d = 1'b0;
    end
    dirty_d = dirty_q;
    if (bram_wr || state_q == FMT) begin
      dirty_d = 1'b1;
    end else if (saveStart || loadDone) begin
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      slot_q     <= '0;
      isLoad_q   <= 1'b0;
      fmtCnt_q   <= 2'd0;
      dirty_q    <= 1'b0;
      bkEna_q    <= 1'b0;
      loadReq_q  <= 1'b0;
      saveReq_q  <= 1'b0;
      fmtReq_q   <= 1'b0;
      download_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      isLoad_q   <= isLoad_d;
      fmtCnt_q   <= fmtCnt_d;
      dirty_q    <= dirty_d;
      bkEna_q    <= bkEna_d;
      loadReq_q  <= load_req;
      saveReq_q  <= save_req;
      fmtReq_q   <= format_req;
      download_q <= download;
      ack_q      <= sd_ack;
    end
  end

  // Outputs decode straight from state so a reset removes them without waiting for a clock.
  assign sd_lba   = 32'({slot_q, idx_q});
  assign sd_rd    = (state_q == REQ) && isLoad_q;
  assign sd_wr    = (state_q == REQ) && !isLoad_q;
  assign loading  = ((state_q == REQ) || (state_q == XFER)) && isLoad_q;
  assign busy     = (state_q != IDLE);
  assign fmt_we   = (state_q == FMT);
  assign fmt_addr = fmtCnt_q;
  assign fmt_data = fmt_we ? BK_FMT_HDR[fmtCnt_q] : 16'h0000;
  assign bk_ena   = bkEna_q;
  assign dirty    = dirty_q;

endmodule
